alu_exec_ctrl: RTL and testbench

- Execute-stage controller that sits directly in front of the 8-bit ALU.
- Holds a small general-purpose register file and accepts one operation at a time over a valid/ready handshake. It drives the ALU operand and select inputs, captures the ALU result and flags, writes the result back and maintains the condition-code register (CCR).
- Throughput is one operation per 2 clocks.

---
 rtl/alu_exec_ctrl_if.sv | 53 +++++
 rtl/alu_exec_ctrl.sv | 112 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_if.sv
// rtl/alu_exec_ctrl_if.sv - operation, load, ALU and debug signal bundle for alu_exec_ctrl
//
// Purpose: groups every non-clock signal of the execute-stage controller.
// Modports:
//   slave  - the controller: takes op/load/debug requests and ALU results,
//            drives op_ready, ALU operands/select, ccr, done and dbg_data.
//   master - the surrounding environment (requester, ALU and debug reader).
// Signals:
//   op_valid/op_ready, op_sel, op_srca, op_srcb, op_dst, op_wen  operation handshake
//   ld_valid, ld_reg, ld_data                                    direct register load
//   alu_a, alu_b, alu_sel, alu_result, alu_nzvc                  ALU connection
//   ccr, done                                                    status
//   dbg_reg, dbg_data                                            debug read port

interface alu_exec_ctrl_if #(
    parameter int IW = 2
) ();
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_sel;
    logic [IW-1:0] op_srca;
    logic [IW-1:0] op_srcb;
    logic [IW-1:0] op_dst;
    logic          op_wen;
    logic          ld_valid;
    logic [IW-1:0] ld_reg;
    logic [7:0]    ld_data;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [7:0]    alu_result;
    logic [3:0]    alu_nzvc;
    logic [3:0]    ccr;
    logic          done;
    logic [IW-1:0] dbg_reg;
    logic [7:0]    dbg_data;

    modport slave (
        input  op_valid, op_sel, op_srca, op_srcb, op_dst, op_wen,
        input  ld_valid, ld_reg, ld_data,
        input  alu_result, alu_nzvc,
        input  dbg_reg,
        output op_ready, alu_a, alu_b, alu_sel, ccr, done, dbg_data
    );

    modport master (
        output op_valid, op_sel, op_srca, op_srcb, op_dst, op_wen,
        output ld_valid, ld_reg, ld_data,
        output alu_result, alu_nzvc,
        output dbg_reg,
        input  op_ready, alu_a, alu_b, alu_sel, ccr, done, dbg_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage controller in front of an 8-bit ALU
//
// Purpose: small register file plus a two-state IDLE/EXEC sequencer. An op
// accepted in IDLE registers its operands onto the ALU inputs; one cycle
// later the ALU result is written back (optionally), the CCR is updated and
// done pulses. One operation every two clocks.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - alu_exec_ctrl_if.slave (op handshake, load port, ALU, ccr, done, debug)

module alu_exec_ctrl #(
    parameter int         NUM_REGS  = 4,
    parameter logic [3:0] CCR_RESET = 4'b0000
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    regs [NUM_REGS];
    logic [IW-1:0] dst_q;
    logic          wen_q;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic [2:0]    alu_sel_q;
    logic [3:0]    ccr_q;
    logic          done_q;
    logic          accept;
    logic          retire;
    logic          logic_op;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                retire  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // alu_sel_q doubles as the latched select of the op in flight.
    // AND/OR leave V and C undefined at the ALU, so those bits are kept.
    assign logic_op = (alu_sel_q[2:1] == 2'b01);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            wen_q     <= 1'b0;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_sel_q <= 3'b000;
            ccr_q     <= CCR_RESET;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            done_q  <= retire;

            // Operands come from the register contents before this edge;
            // a same-edge load or writeback is deliberately not forwarded.
            if (accept) begin
                alu_a_q   <= regs[bus.op_srca];
                alu_b_q   <= regs[bus.op_srcb];
                alu_sel_q <= bus.op_sel;
                dst_q     <= bus.op_dst;
                wen_q     <= bus.op_wen;
            end

            if (retire) begin
                ccr_q <= logic_op ? {bus.alu_nzvc[3:2], ccr_q[1:0]} : bus.alu_nzvc;
            end

            // Writeback has priority over a load to the same register.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (retire && wen_q && (dst_q == IW'(i))) begin
                    regs[i] <= bus.alu_result;
                end else if (bus.ld_valid && (bus.ld_reg == IW'(i))) begin
                    regs[i] <= bus.ld_data;
                end
            end
        end
    end

    assign bus.op_ready = (state_q == IDLE);
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_sel  = alu_sel_q;
    assign bus.ccr      = ccr_q;
    assign bus.done     = done_q;
    assign bus.dbg_data = regs[bus.dbg_reg];
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking bench for alu_exec_ctrl

module tb_alu_exec_ctrl;
    logic clk;
    logic rst;

    alu_exec_ctrl_if #(.IW(2)) bus ();

    alu_exec_ctrl #(.NUM_REGS(4), .CCR_RESET(4'b0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_regs [4];
    logic [3:0] m_ccr;
    logic [1:0] junk_vc;
    logic [3:0] nzvc_xor;

    // Behavioural ALU: result plus {N,Z,V,C}; logic ops report junk V/C.
    function automatic logic [11:0] alu_fn(input logic [2:0] s, input logic [7:0] a,
                                           input logic [7:0] b, input logic [1:0] junk,
                                           input logic [3:0] xr);
        logic [8:0] w;
        logic [7:0] r, x, y;
        logic       v, c, sub;
        x = a; y = b; sub = 1'b0;
        if (s == 3'd1) sub = 1'b1;
        if (s == 3'd4) y = 8'd1;
        if (s == 3'd5) begin x = b; y = 8'd1; end
        if (s == 3'd6) begin y = 8'd1; sub = 1'b1; end
        if (s == 3'd7) begin x = b; y = 8'd1; sub = 1'b1; end
        if (s == 3'd2 || s == 3'd3) begin
            r = (s == 3'd2) ? (a & b) : (a | b);
            v = junk[1];
            c = junk[0];
        end else if (sub) begin
            w = {1'b0, x} - {1'b0, y};
            r = w[7:0];
            c = w[8];
            v = (x[7] != y[7]) && (r[7] != x[7]);
        end else begin
            w = {1'b0, x} + {1'b0, y};
            r = w[7:0];
            c = w[8];
            v = (x[7] == y[7]) && (r[7] != x[7]);
        end
        return {r, {r[7], (r == 8'h00), v, c} ^ xr};
    endfunction

    assign {bus.alu_result, bus.alu_nzvc} = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b, junk_vc, nzvc_xor);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_regs(input string nm);
        for (int i = 0; i < 4; i++) begin
            bus.dbg_reg = 2'(i);
            #1;
            chk(nm, bus.dbg_data, m_regs[i]);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic load(input logic [1:0] r, input logic [7:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_reg   = r;
        bus.ld_data  = d;
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        m_regs[r]    = d;
        @(negedge clk);
    endtask

    // Issues one op, optionally with a load landing on the retire edge, and
    // checks it against the model. Called and returns at a falling edge.
    task automatic run_op(input logic [2:0] sel, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] d, input logic w, input logic ldv,
                          input logic [1:0] lr, input logic [7:0] ldd);
        logic [7:0]  ea, eb, er;
        logic [3:0]  ef, eccr;
        int          n;
        ea      = m_regs[sa];
        eb      = m_regs[sb];
        junk_vc = ~m_ccr[1:0];
        {er, ef} = alu_fn(sel, ea, eb, junk_vc, nzvc_xor);
        eccr = (sel == 3'd2 || sel == 3'd3) ? {ef[3:2], m_ccr[1:0]} : ef;
        bus.op_valid = 1'b1;
        bus.op_sel   = sel;
        bus.op_srca  = sa;
        bus.op_srcb  = sb;
        bus.op_dst   = d;
        bus.op_wen   = w;
        n = 0;
        while (!bus.op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk("op_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        chk("alu_a", bus.alu_a, ea);
        chk("alu_b", bus.alu_b, eb);
        chk("alu_sel", bus.alu_sel, sel);
        chk("exec_ready", bus.op_ready, 0);
        chk("exec_done", bus.done, 0);
        if (ldv) begin
            bus.ld_valid = 1'b1;
            bus.ld_reg   = lr;
            bus.ld_data  = ldd;
        end
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        if (ldv) m_regs[lr] = ldd;
        if (w) m_regs[d] = er;
        m_ccr = eccr;
        chk("retire_done", bus.done, 1);
        chk("retire_ready", bus.op_ready, 1);
        chk("ccr", bus.ccr, m_ccr);
        chk_regs("regs");
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] eccr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [11:0] rr;

        tbl[0]  = '{3'd0, 2'd0, 2'd1, 8'h7f, 8'h01, 4'b1010};
        tbl[1]  = '{3'd1, 2'd2, 2'd1, 8'h80, 8'h01, 4'b0010};
        tbl[2]  = '{3'd2, 2'd0, 2'd2, 8'h7f, 8'h80, 4'b0110};
        tbl[3]  = '{3'd0, 2'd3, 2'd1, 8'hff, 8'h01, 4'b0101};
        tbl[4]  = '{3'd3, 2'd2, 2'd1, 8'h80, 8'h01, 4'b1001};
        tbl[5]  = '{3'd5, 2'd1, 2'd0, 8'h01, 8'h7f, 4'b1010};
        tbl[6]  = '{3'd6, 2'd2, 2'd0, 8'h80, 8'h7f, 4'b0010};
        tbl[7]  = '{3'd7, 2'd0, 2'd1, 8'h7f, 8'h01, 4'b0100};
        tbl[8]  = '{3'd1, 2'd1, 2'd3, 8'h01, 8'hff, 4'b0001};
        tbl[9]  = '{3'd2, 2'd3, 2'd0, 8'hff, 8'h7f, 4'b0001};
        tbl[10] = '{3'd4, 2'd3, 2'd2, 8'hff, 8'h80, 4'b0101};

        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op_sel = 3'd0; bus.op_srca = 2'd0; bus.op_srcb = 2'd0;
        bus.op_dst = 2'd0; bus.op_wen = 1'b0; bus.ld_valid = 1'b0; bus.ld_reg = 2'd0;
        bus.ld_data = 8'h00; bus.dbg_reg = 2'd0;
        junk_vc = 2'b00; nzvc_xor = 4'b0000;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ccr = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_ccr", bus.ccr, 4'b0000);
        chk("rst_alu_a", bus.alu_a, 8'h00);
        chk("rst_alu_b", bus.alu_b, 8'h00);
        chk("rst_alu_sel", bus.alu_sel, 3'b000);
        chk_regs("rst_regs");
        @(negedge clk);
        rst = 1'b0;

        // ADD 0x7F + 0x01 -> r2
        load(2'd0, 8'h7f);
        load(2'd1, 8'h01);
        run_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, 8'h00);
        chk("add_ccr", bus.ccr, 4'b1010);
        bus.dbg_reg = 2'd2; #1;
        chk("add_r2", bus.dbg_data, 8'h80);

        // SUB preloads CCR=1011, then OR keeps V/C
        load(2'd0, 8'h00);
        load(2'd1, 8'h01);
        load(2'd3, 8'h00);
        nzvc_xor = 4'b0010;
        run_op(3'd1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("sub_pre_ccr", bus.ccr, 4'b1011);
        nzvc_xor = 4'b0000;
        run_op(3'd3, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("or_keep_vc", bus.ccr, 4'b0111);

        // Compare: SUB 5-5 with wen=0
        load(2'd0, 8'h05);
        load(2'd1, 8'h05);
        run_op(3'd1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("cmp_z", bus.ccr, 4'b0100);

        // op_valid held 6 cycles with INCA r0 -> r0
        load(2'd0, 8'hff);
        junk_vc = 2'b00;
        bus.op_valid = 1'b1; bus.op_sel = 3'd4; bus.op_srca = 2'd0; bus.op_srcb = 2'd0;
        bus.op_dst = 2'd0; bus.op_wen = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            chk("hold_ready", bus.op_ready, (k % 2 == 0) ? 1 : 0);
            if (bus.op_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        chk("hold_accepts", acc, 3);
        for (int k = 0; k < 3; k++) begin
            rr = alu_fn(3'd4, m_regs[0], m_regs[0], 2'b00, 4'b0000);
            m_regs[0] = rr[11:4];
            m_ccr = rr[3:0];
        end
        bus.dbg_reg = 2'd0; #1;
        chk("hold_r0", bus.dbg_data, 8'h02);
        chk("hold_ccr", bus.ccr, m_ccr);
        @(negedge clk);

        // Writeback vs load collisions
        load(2'd0, 8'h10);
        load(2'd1, 8'h20);
        run_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 2'd2, 8'h55);
        bus.dbg_reg = 2'd2; #1;
        chk("wb_wins", bus.dbg_data, 8'h30);
        @(negedge clk);
        run_op(3'd1, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 2'd3, 8'h55);
        bus.dbg_reg = 2'd2; #1;
        chk("both_r2", bus.dbg_data, 8'h10);
        bus.dbg_reg = 2'd3; #1;
        chk("both_r3", bus.dbg_data, 8'h55);
        @(negedge clk);

        // Vector table
        load(2'd0, 8'h7f);
        load(2'd1, 8'h01);
        load(2'd2, 8'h80);
        load(2'd3, 8'hff);
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].sel, tbl[i].sa, tbl[i].sb, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);
            chk("tbl_ccr", bus.ccr, tbl[i].eccr);
            chk("tbl_a_hold", bus.alu_a, tbl[i].ea);
            chk("tbl_b_hold", bus.alu_b, tbl[i].eb);
        end

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) load(2'($urandom_range(0, 3)), 8'($urandom));
            run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during EXEC aborts the op
        load(2'd0, 8'h40);
        load(2'd1, 8'h40);
        bus.op_valid = 1'b1; bus.op_sel = 3'd0; bus.op_srca = 2'd0; bus.op_srcb = 2'd1;
        bus.op_dst = 2'd2; bus.op_wen = 1'b1;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        chk("abort_in_exec", bus.op_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ccr = 4'b0000;
        chk("abort_done", bus.done, 0);
        chk("abort_ready", bus.op_ready, 1);
        chk("abort_ccr", bus.ccr, 4'b0000);
        chk_regs("abort_regs");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done_after", bus.done, 0);
        chk("abort_ready_after", bus.op_ready, 1);
        chk_regs("abort_regs_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
